cache_axi_bridge: RTL and testbench

CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

---
 rtl/cache_axi_bridge.sv | 181 ++++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_bridge.sv
// Bridges two sram-like ports (inst, data) onto a single AXI master, one transaction
// at a time. The IDLE grant is combinational; address, size and data are registered.
module cache_axi_bridge #(
    parameter int ADDR_W    = 32,
    parameter int INST_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [ADDR_W-1:0] inst_wdata,
    output logic [ADDR_W-1:0] inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [ADDR_W-1:0] data_wdata,
    output logic [ADDR_W-1:0] data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,

    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,

    input  logic [ADDR_W-1:0] rdata,
    input  logic              rvalid,
    output logic              rready,

    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,

    output logic [ADDR_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,

    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    state_t            state, state_nxt;
    logic              owner_data;  // 0 = inst owns the transaction, 1 = data
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] wdata_q;
    logic              aw_done, w_done;
    logic              grant_inst, grant_data, grant, grant_wr;
    logic              done_ok;

    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (state == IDLE && !rst) begin
            if (INST_PRIO != 0) begin
                grant_inst = inst_req;
                grant_data = data_req && !inst_req;
            end else begin
                grant_data = data_req;
                grant_inst = inst_req && !data_req;
            end
        end
    end

    assign grant    = grant_inst | grant_data;
    assign grant_wr = grant_data ? data_wr : inst_wr;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        arvalid   = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        rready    = 1'b0;
        bready    = 1'b0;
        done_ok   = 1'b0;
        case (state)
            IDLE:    if (grant) state_nxt = grant_wr ? WR_REQ : RD_ADDR;
            RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    done_ok   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WR_REQ: begin
                // AW and W run independently; leave once both have completed,
                // whether in the same cycle or apart.
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || wready)) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    done_ok   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            arvalid = 1'b0;
            awvalid = 1'b0;
            wvalid  = 1'b0;
            rready  = 1'b0;
            bready  = 1'b0;
            done_ok = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_data <= 1'b0;
            wr_q       <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            if (grant) begin
                owner_data <= grant_data;
                wr_q       <= grant_wr;
                size_q     <= grant_data ? data_size  : inst_size;
                addr_q     <= grant_data ? data_addr  : inst_addr;
                wdata_q    <= grant_data ? data_wdata : inst_wdata;
                aw_done    <= 1'b0;
                w_done     <= 1'b0;
            end
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready)   w_done  <= 1'b1;
        end
    end

    always_comb begin
        case (size_q)
            2'd0:    wstrb = 4'b0001 << addr_q[1:0];
            2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
    end

    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign arsize = {1'b0, size_q};
    assign awsize = {1'b0, size_q};
    assign wdata  = wdata_q;

    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;
    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = done_ok && !owner_data;
    assign data_data_ok = done_ok && owner_data;

    // Keeps wr_q observable for debug; the state already encodes direction.
    logic unused_ok;
    assign unused_ok = wr_q;

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Randomised bench: sram masters and an AXI memory slave drive the bridge; a monitor
// checks each grant/completion and every AXI beat against a word-memory reference.
module tb_cache_axi_bridge;
    localparam int INST_PRIO = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic [3:0]  wstrb;
    logic        arvalid, arready, rvalid, rready, awvalid, awready;
    logic        wvalid, wready, bvalid, bready;

    cache_axi_bridge #(.ADDR_W(32), .INST_PRIO(INST_PRIO)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- memories: slave-side and reference ----------------
    logic [31:0] slv_mem [int];
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] init_word(input int w);
        logic [31:0] x;
        x = 32'(w);
        return (x * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] slv_get(input int w);
        return slv_mem.exists(w) ? slv_mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] ref_get(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    // Byte lanes touched by an access: the naturally aligned group of 1/2/4 bytes.
    function automatic logic [3:0] lanes(input logic [1:0] sz, input logic [1:0] a);
        int n, base;
        logic [3:0] s;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = int'(a) - (int'(a) % n);
        s = 4'b0000;
        for (int i = 0; i < 4; i++) if (i >= base && i < base + n) s[i] = 1'b1;
        return s;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        slv_mem[int'(a[31:2])] = v;
        ref_mem[int'(a[31:2])] = v;
    endtask

    // ---------------- AXI slave ----------------
    int p_ar = 100, p_r = 100, p_aw = 100, p_w = 100, p_b = 100, aw_delay = 0;
    bit rd_pend = 0, aw_got = 0, w_got = 0, b_pend = 0;
    int rd_w, aw_w, aw_cnt = 0;
    logic [31:0] w_d, sv;
    logic [3:0] w_s;

    function automatic bit roll(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    initial begin
        arready = 0; rvalid = 0; rdata = 0; awready = 0; wready = 0; bvalid = 0;
        forever begin
            @(posedge clk);
            if (rvalid && rready) rd_pend = 0;
            if (arvalid && arready) begin rd_pend = 1; rd_w = int'(araddr[31:2]); end
            if (bvalid && bready) begin aw_got = 0; w_got = 0; b_pend = 0; end
            if (awvalid && awready) begin aw_got = 1; aw_w = int'(awaddr[31:2]); aw_cnt = 0; end
            else if (awvalid) aw_cnt++;
            if (wvalid && wready) begin w_got = 1; w_d = wdata; w_s = wstrb; end
            if (aw_got && w_got && !b_pend) begin
                sv = slv_get(aw_w);
                for (int i = 0; i < 4; i++) if (w_s[i]) sv[8*i +: 8] = w_d[8*i +: 8];
                slv_mem[aw_w] = sv;
                b_pend = 1;
            end
            #1;
            arready = roll(p_ar);
            rvalid  = rd_pend && (rvalid || roll(p_r));
            rdata   = rvalid ? slv_get(rd_w) : $urandom;
            awready = (aw_cnt >= aw_delay) && roll(p_aw);
            wready  = roll(p_w);
            bvalid  = b_pend && (bvalid || roll(p_b));
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        bit          port;   // 1 = data
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur, e_m;
    bit busy = 0, ar_done = 0, aw_done = 0, w_done = 0, dok;
    logic [31:0] v_m;
    logic [3:0] s_m;
    int w_m;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_outputs_low", {arvalid, awvalid, wvalid, rready, bready,
                inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
            exp_q.delete();
            busy = 0;
        end else begin
            if (arvalid) begin
                chk("arvalid_legal", busy && !cur.wr && !ar_done, 1);
                chk("araddr", araddr, cur.addr);
                chk("arsize", arsize, {1'b0, cur.size});
            end
            if (rready) chk("rready_legal", busy && !cur.wr && ar_done, 1);
            if (awvalid) begin
                chk("awvalid_legal", busy && cur.wr && !aw_done, 1);
                chk("awaddr", awaddr, cur.addr);
                chk("awsize", awsize, {1'b0, cur.size});
            end
            if (wvalid) begin
                chk("wvalid_legal", busy && cur.wr && !w_done, 1);
                chk("wdata", wdata, cur.wdata);
                chk("wstrb", wstrb, lanes(cur.size, cur.addr[1:0]));
            end
            if (bready) chk("bready_legal", busy && cur.wr && aw_done && w_done, 1);
            if (arvalid && arready) ar_done = 1;
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;

            dok = inst_data_ok || data_data_ok;
            if (dok) begin
                chk("data_ok_exclusive", inst_data_ok && data_data_ok, 0);
                chk("data_ok_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e_m = exp_q.pop_front();
                    chk("data_ok_port", data_data_ok, e_m.port);
                    if (e_m.wr) chk("data_ok_on_b", bvalid && bready, 1);
                    else begin
                        chk("data_ok_on_r", rvalid && rready, 1);
                        chk("rdata", e_m.port ? data_rdata : inst_rdata, e_m.rdata);
                    end
                end
                busy = 0;
            end

            if (inst_addr_ok || data_addr_ok) begin
                chk("addr_ok_exclusive", inst_addr_ok && data_addr_ok, 0);
                chk("grant_when_free", busy || dok, 0);
                if (inst_req && data_req) chk("arb_winner_data", data_addr_ok, INST_PRIO == 0);
                chk("grant_has_req", data_addr_ok ? data_req : inst_req, 1);
                e_m.port  = data_addr_ok;
                e_m.wr    = data_addr_ok ? data_wr    : inst_wr;
                e_m.size  = data_addr_ok ? data_size  : inst_size;
                e_m.addr  = data_addr_ok ? data_addr  : inst_addr;
                e_m.wdata = data_addr_ok ? data_wdata : inst_wdata;
                w_m = int'(e_m.addr[31:2]);
                if (e_m.wr) begin
                    v_m = ref_get(w_m);
                    s_m = lanes(e_m.size, e_m.addr[1:0]);
                    for (int i = 0; i < 4; i++) if (s_m[i]) v_m[8*i +: 8] = e_m.wdata[8*i +: 8];
                    ref_mem[w_m] = v_m;
                    e_m.rdata = 32'h0;
                end else e_m.rdata = ref_get(w_m);
                exp_q.push_back(e_m);
                cur = e_m;
                busy = 1; ar_done = 0; aw_done = 0; w_done = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input bit p, input bit rq, input bit w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d);
        if (p) begin data_req = rq; data_wr = w; data_size = sz; data_addr = a; data_wdata = d; end
        else   begin inst_req = rq; inst_wr = w; inst_size = sz; inst_addr = a; inst_wdata = d; end
    endtask

    function automatic logic sig(input int k);
        case (k)
            0:       return data_data_ok;
            1:       return inst_data_ok;
            2:       return rready;
            3:       return bready;
            default: return inst_addr_ok;
        endcase
    endfunction

    task automatic wait_for(input int k, input int budget, input string name, output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!sig(k) && cyc < budget);
        chk(name, sig(k), 1);
    endtask

    task automatic master(input bit p, input int n);
        int t;
        bit got;
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            a = 32'h0000_1000 + ($urandom % 32);
            set_req(p, 1'b1, 1'($urandom % 2), 2'($urandom % 3), a, $urandom);
            got = 0; t = 0;
            while (!got && t < 3000) begin
                @(negedge clk); t++;
                got = p ? data_addr_ok : inst_addr_ok;
            end
            if (!got) begin
                chk(p ? "data_master_grant" : "inst_master_grant", got, 1);
                set_req(p, 0, 0, 0, 0, 0);
                return;
            end
            @(posedge clk); #1;
            set_req(p, 0, 0, 0, 0, 0);
            repeat ($urandom % 3) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    int cyc;

    initial begin
        rst = 1;
        set_req(0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("idle_after_reset", {arvalid, awvalid, wvalid, rready, bready,
            inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);

        // single read, minimum latency
        preload(32'h1FC00004, 32'hDEADBEEF);
        @(posedge clk); #1 set_req(1, 1, 0, 2'd2, 32'h1FC00004, 0);
        @(negedge clk); chk("rd_addr_ok_c0", data_addr_ok, 1);
        @(posedge clk); #1 set_req(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rd_arvalid_c1", arvalid, 1);
        chk("rd_araddr_c1", araddr, 32'h1FC00004);
        chk("rd_arsize_c1", arsize, 3'd2);
        @(negedge clk);
        chk("rd_data_ok_c2", data_data_ok, 1);
        chk("rd_rdata_c2", data_rdata, 32'hDEADBEEF);

        // simultaneous requests: data first, inst granted the cycle after data_ok
        @(posedge clk); #1;
        set_req(0, 1, 0, 2'd2, 32'h1FC00008, 0);
        set_req(1, 1, 0, 2'd2, 32'h1FC0000C, 0);
        @(negedge clk);
        chk("arb_data_first", data_addr_ok, 1);
        chk("arb_inst_held", inst_addr_ok, 0);
        @(posedge clk); #1 set_req(1, 0, 0, 0, 0, 0);
        wait_for(0, 20, "arb_data_done", cyc);
        chk("arb_no_grant_on_dok", inst_addr_ok, 0);
        @(negedge clk); chk("arb_inst_next_cycle", inst_addr_ok, 1);
        @(posedge clk); #1 set_req(0, 0, 0, 0, 0, 0);
        wait_for(1, 20, "arb_inst_done", cyc);

        // byte write, awready held off three cycles
        aw_delay = 3;
        @(posedge clk); #1 set_req(1, 1, 1, 2'd0, 32'h00000003, 32'hAB000000);
        @(negedge clk); chk("bw_addr_ok", data_addr_ok, 1);
        @(posedge clk); #1 set_req(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("bw_both_valid", {awvalid, wvalid}, 2'b11);
        chk("bw_wstrb", wstrb, 4'b1000);
        @(negedge clk);
        chk("bw_w_dropped", {awvalid, wvalid, bready}, 3'b100);
        wait_for(3, 12, "bw_bready", cyc);
        chk("bw_bready_cycle", cyc, 3);
        chk("bw_valids_done", {awvalid, wvalid}, 0);
        chk("bw_data_ok", data_data_ok, 1);
        aw_delay = 0;

        // half-word write on the upper half
        @(posedge clk); #1 set_req(1, 1, 1, 2'd1, 32'h00002002, 32'h12345678);
        @(negedge clk); chk("hw_addr_ok", data_addr_ok, 1);
        @(posedge clk); #1 set_req(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("hw_wstrb", wstrb, 4'b1100);
        chk("hw_awsize", awsize, 3'd1);
        wait_for(0, 20, "hw_done", cyc);

        // reset while waiting for read data; the late response must be ignored
        p_r = 0;
        @(posedge clk); #1 set_req(1, 1, 0, 2'd2, 32'h1FC00010, 0);
        @(negedge clk); chk("rr_addr_ok", data_addr_ok, 1);
        @(posedge clk); #1 set_req(1, 0, 0, 0, 0, 0);
        wait_for(2, 10, "rr_in_rd_data", cyc);
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        @(posedge clk); #1 rst = 0; p_r = 100;
        repeat (4) begin
            @(negedge clk);
            chk("rr_no_response", {inst_data_ok, data_data_ok, rready, arvalid}, 0);
        end
        chk("rr_late_rvalid_present", rvalid, 1);
        @(posedge clk); #1 rd_pend = 0;
        repeat (2) begin @(posedge clk); #1; end
        set_req(0, 1, 0, 2'd2, 32'h1FC00010, 0);
        @(negedge clk); chk("rr_idle_grant", inst_addr_ok, 1);
        @(posedge clk); #1 set_req(0, 0, 0, 0, 0, 0);
        wait_for(1, 20, "rr_next_serviced", cyc);

        // randomised traffic from both ports with random AXI back-pressure
        p_ar = 60; p_r = 60; p_aw = 60; p_w = 60; p_b = 60;
        @(posedge clk); #1;
        fork
            master(1'b0, 50);
            master(1'b1, 50);
        join
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin @(negedge clk); cyc++; end
        chk("drain_outstanding", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
